i2s_src_sched: RTL and testbench
================================

# i2s_src_sched

Frame-rate sample scheduler between several audio sample sources and the I2S serializer. Each serializer `load` pulse schedules one stereo sample for the next frame. The block picks one requesting source by fixed-priority or round-robin arbitration, optionally keeps a streaming source locked in, and hands its 24-bit left/right words to the serializer. If no source is ready it mutes the output and flags an underrun.

## Interface
- `NSRC`, 4: number of sample sources, 2..8.
- `DW`, 24: sample width, two's complement.
- `clk` input 1: system clock (16 MHz); also the domain of the serializer `load`.
- `reset` input 1: asynchronous, active-low; all state and outputs clear while low.
- `load` input 1: one-cycle pulse from the serializer, once per frame; the serializer latches `l_data`/`r_data` in that cycle.
- `req` input NSRC: per-source "sample ready" level.
- `src_l` input NSRC*DW: left samples, source i at bits [i*DW +: DW].
- `src_r` input NSRC*DW: right samples, same packing.
- `mask` input NSRC: 1 = source allowed to win.
- `rr_mode` input 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `lock_en` input 1: 1 = current owner keeps the grant while its `req` stays high.
- `ack` output NSRC: one-cycle pulse to the winner when its sample is taken.
- `l_data` output DW: left sample presented to the serializer.
- `r_data` output DW: right sample presented to the serializer.
- `grant_vld` output 1: 1 = the presented sample came from a source.
- `grant_id` output clog2(NSRC): source of the presented sample.
- `underrun` output 1: one-cycle pulse when no eligible source exists.
- `overrun` output 1: one-cycle pulse when `load` arrives while not IDLE.

## Operation
- Reset values: `l_data` = 0, `r_data` = 0, `ack` = 0, `grant_vld` = 0, `grant_id` = 0, `underrun` = 0, `overrun` = 0. RR pointer = 0, lock owner invalid, FSM = IDLE.
- FSM states are IDLE, ARB, XFER.
- IDLE: on `load`, go to ARB. The serializer takes the words already presented.
- ARB: `elig` = `req & mask`.
  - If lock is valid, `lock_en` = 1, and `elig[owner]` = 1: winner = owner.
  - Else if `rr_mode` = 1: winner = first set bit of `elig` searching from `ptr` upward, wrapping modulo NSRC.
  - Else: winner = lowest set bit of `elig`.
  - Register the winner and a found flag. Go to XFER.
- XFER, found:
  - `l_data`/`r_data` take the winner's words.
  - `ack[winner]` pulses.
  - `grant_vld` = 1, `grant_id` = winner.
  - `ptr` = winner + 1 mod NSRC. Lock owner = winner if `lock_en`, else invalid.
  - Go to IDLE.
- XFER, none found:
  - `l_data` = `r_data` = 0, `grant_vld` = 0, `grant_id` is held.
  - `underrun` pulses. Lock goes invalid, `ptr` is unchanged.
  - Go to IDLE.
- A source deasserts `req` or drops from `mask` only after `ack`. If `req` falls between ARB and XFER, the sample is still taken and acked.
- `lock_en` falling releases the lock at the next arbitration. A masked owner loses the lock.
- `load` in ARB or XFER is ignored and pulses `overrun` the following cycle. The FSM sequence is unaffected.
- `mask`, `rr_mode` and `lock_en` are sampled in ARB only.

## Timing
- `load` at cycle t: ARB at t+1, XFER at t+2. New `l_data`/`r_data`, `ack`, `grant_*` and `underrun` are visible at t+3 and stable until the next XFER.
- Fixed latency of 3 cycles from `load` to the new presented sample. Minimum `load` spacing is 3 cycles; the I2S frame is ≥64 cycles.
- Outputs are registered. `ack` and `underrun` are exactly one cycle wide.
- When `reset` deasserts, the first `load` is honoured no earlier than the first rising edge after deassertion.
- If `reset` asserts mid-sequence, the FSM returns to IDLE immediately. No `ack` issues for an interrupted XFER.

## Structure
- The shared `i2s_pkg` holds:
  - state encodings IDLE/ARB/XFER;
  - the default sample width of 24;
  - a `clog2` function.
- One sub-module, `rr_pick`: combinational find-first-set from a start pointer with wrap. It is used for both modes, with start = 0 for fixed priority.
- Data muxing and the FSM are in the top.

## Test plan
- Fixed priority, `rr_mode`=0, `req`=4'b1010, `mask`=4'hF, `load` → `ack`=4'b0010, `grant_id`=1, `l_data`=src_l[1] at t+3.
- Round-robin, `req`=4'hF held, 5 loads → `grant_id` sequence 0,1,2,3,0 with one `ack` per load.
- Lock, `lock_en`=1, source 2 alone, then `req`=4'hF → source 2 keeps winning until its `req` drops, then the next load grants 3.
- Underrun, `req`=0 or `mask`=0 → `l_data`=`r_data`=0, `grant_vld`=0, one `underrun` pulse, `ptr` unchanged.
- Overrun: `load` at t and t+1 → single `ack`, `overrun` pulse at t+2, FSM back in IDLE at t+3.
- Reset low during ARB → all outputs 0, no `ack`. After release, the next `load` arbitrates normally from `ptr`=0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S sample scheduler: FSM encodings, default sample width, clog2.
// Pure package: no latency or backpressure of its own.
package i2s_pkg;

  localparam int I2S_DW = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  // Never returns less than 1 so a 1-source index still has a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Find-first-set over elig starting at start, wrapping modulo N; start = 0 gives fixed priority.
// Combinational, zero latency; no backpressure.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int pos;
    pos   = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(start) + k) % N;
      if (!found && elig[pos]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/i2s_src_sched.sv
// Per-frame source arbiter feeding the I2S serializer; load -> new sample/ack/underrun in 3 cycles.
// No backpressure: a load arriving mid-sequence is dropped and flagged as overrun.
module i2s_src_sched import i2s_pkg::*; #(
  parameter int  NSRC = 4,
  parameter int  DW   = I2S_DW,
  localparam int IW   = clog2(NSRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [NSRC-1:0]    req,
  input  logic [NSRC*DW-1:0] src_l,
  input  logic [NSRC*DW-1:0] src_r,
  input  logic [NSRC-1:0]    mask,
  input  logic               rr_mode,
  input  logic               lock_en,
  output logic [NSRC-1:0]    ack,
  output logic [DW-1:0]      l_data,
  output logic [DW-1:0]      r_data,
  output logic               grant_vld,
  output logic [IW-1:0]      grant_id,
  output logic               underrun,
  output logic               overrun
);

  state_t state_q, state_d;

  logic [IW-1:0]   ptr_q, ptr_d, win_q, win_d, lock_id_q, lock_id_d, gid_q, gid_d;
  logic            found_q, found_d, lock_vld_q, lock_vld_d, lock_arm_q, lock_arm_d;
  logic            gv_q, gv_d, und_q, und_d, ovr_q, ovr_d;
  logic [NSRC-1:0] ack_q, ack_d;
  logic [DW-1:0]   l_q, l_d, r_q, r_d;

  logic [NSRC-1:0] elig;
  logic            lock_hit, pick_found;
  logic [IW-1:0]   pick_start, pick_idx, ptr_inc;

  assign elig       = req & mask;
  assign lock_hit   = lock_vld_q && lock_en && elig[lock_id_q];
  assign pick_start = rr_mode ? ptr_q : '0;
  assign ptr_inc    = (win_q == IW'(NSRC - 1)) ? '0 : win_q + 1'b1;

  rr_pick #(.N(NSRC), .IW(IW)) u_pick (
    .elig  (elig),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_ARB;
      ST_ARB:  state_d = ST_XFER;
      ST_XFER: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    win_d      = win_q;
    found_d    = found_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    lock_arm_d = lock_arm_q;
    gid_d      = gid_q;
    gv_d       = gv_q;
    l_d        = l_q;
    r_d        = r_q;
    ack_d      = '0;
    und_d      = 1'b0;
    ovr_d      = load && (state_q != ST_IDLE);
    case (state_q)
      ST_ARB: begin
        win_d      = lock_hit ? lock_id_q : pick_idx;
        found_d    = lock_hit || pick_found;
        lock_arm_d = lock_en;
      end
      ST_XFER: begin
        if (found_q) begin
          l_d          = src_l[win_q*DW +: DW];
          r_d          = src_r[win_q*DW +: DW];
          ack_d[win_q] = 1'b1;
          gv_d         = 1'b1;
          gid_d        = win_q;
          ptr_d        = ptr_inc;
          lock_vld_d   = lock_arm_q;
          lock_id_d    = win_q;
        end else begin
          // Mute and keep grant_id/ptr so the next frame resumes where it left off.
          l_d        = '0;
          r_d        = '0;
          gv_d       = 1'b0;
          und_d      = 1'b1;
          lock_vld_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      win_q      <= '0;
      found_q    <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
      lock_arm_q <= 1'b0;
      gid_q      <= '0;
      gv_q       <= 1'b0;
      l_q        <= '0;
      r_q        <= '0;
      ack_q      <= '0;
      und_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      found_q    <= found_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      lock_arm_q <= lock_arm_d;
      gid_q      <= gid_d;
      gv_q       <= gv_d;
      l_q        <= l_d;
      r_q        <= r_d;
      ack_q      <= ack_d;
      und_q      <= und_d;
      ovr_q      <= ovr_d;
    end
  end

  assign ack       = ack_q;
  assign l_data    = l_q;
  assign r_data    = r_q;
  assign grant_vld = gv_q;
  assign grant_id  = gid_q;
  assign underrun  = und_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_i2s_src_sched.sv
// Scoreboard bench for i2s_src_sched: directed loads push expected grants, a negedge monitor pops and compares.
module tb_i2s_src_sched;

  localparam int NSRC = 4;
  localparam int DW   = 24;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               load = 1'b0;
  logic               rr_mode = 1'b0;
  logic               lock_en = 1'b0;
  logic [NSRC-1:0]    req = '0;
  logic [NSRC-1:0]    mask = '0;
  logic [NSRC*DW-1:0] src_l;
  logic [NSRC*DW-1:0] src_r;
  logic [NSRC-1:0]    ack;
  logic [DW-1:0]      l_data, r_data;
  logic               grant_vld, underrun, overrun;
  logic [1:0]         grant_id;

  i2s_src_sched #(.NSRC(NSRC), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .req       (req),
    .src_l     (src_l),
    .src_r     (src_r),
    .mask      (mask),
    .rr_mode   (rr_mode),
    .lock_en   (lock_en),
    .ack       (ack),
    .l_data    (l_data),
    .r_data    (r_data),
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .underrun  (underrun),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  ack;
    logic [23:0] l;
    logic [23:0] r;
    logic        gv;
    logic [1:0]  gid;
    logic        und;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ov_cnt = 0;
  int         ov_cyc = -1;
  logic [1:0] last_gid = 2'd0;

  function automatic logic [23:0] lval(input int i);
    return 24'h800001 + 24'(i * 32'h010101);
  endfunction

  function automatic logic [23:0] rval(input int i);
    return 24'h0F0F00 + 24'(i);
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Expected response for a load issued in cycle c; exp_id < 0 means underrun.
  function automatic exp_t make_exp(input int c, input int exp_id);
    exp_t x;
    x.cyc = c + 3;
    if (exp_id < 0) begin
      x.ack = 4'b0000; x.l = 24'h0; x.r = 24'h0; x.gv = 1'b0; x.gid = last_gid; x.und = 1'b1;
    end else begin
      x.ack = 4'b0001 << exp_id; x.l = lval(exp_id); x.r = rval(exp_id);
      x.gv = 1'b1; x.gid = 2'(exp_id); x.und = 1'b0;
      last_gid = 2'(exp_id);
    end
    return x;
  endfunction

  task automatic do_load(input logic [3:0] r_i, input logic [3:0] m_i,
                         input logic rr_i, input logic le_i, input int exp_id);
    @(negedge clk);
    req = r_i; mask = m_i; rr_mode = rr_i; lock_en = le_i; load = 1'b1;
    sb.push_back(make_exp(cyc, exp_id));
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ack"},      int'(ack),       0);
    check({tag, "_l_data"},   int'(l_data),    0);
    check({tag, "_r_data"},   int'(r_data),    0);
    check({tag, "_grant_vld"},int'(grant_vld), 0);
    check({tag, "_grant_id"}, int'(grant_id),  0);
    check({tag, "_underrun"}, int'(underrun),  0);
    check({tag, "_overrun"},  int'(overrun),   0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (overrun) begin
        ov_cnt++;
        ov_cyc = cyc;
      end
      if (ack != 4'b0000 || underrun) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_grant: got ack=%b und=%b at cyc %0d, required no grant", ack, underrun, cyc);
        end else begin
          e = sb.pop_front();
          if (cyc != e.cyc || ack != e.ack || l_data != e.l || r_data != e.r ||
              grant_vld != e.gv || grant_id != e.gid || underrun != e.und) begin
            n_bad++;
            $display("FAIL grant: got cyc=%0d ack=%b l=%h r=%h vld=%b id=%0d und=%b, required cyc=%0d ack=%b l=%h r=%h vld=%b id=%0d und=%b",
                     cyc, ack, l_data, r_data, grant_vld, grant_id, underrun,
                     e.cyc, e.ack, e.l, e.r, e.gv, e.gid, e.und);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    for (int i = 0; i < NSRC; i++) begin
      src_l[i*DW +: DW] = lval(i);
      src_r[i*DW +: DW] = rval(i);
    end
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    // Round-robin with all sources requesting, pointer starts at 0.
    do_load(4'hF, 4'hF, 1'b1, 1'b0, 0);
    do_load(4'hF, 4'hF, 1'b1, 1'b0, 1);
    do_load(4'hF, 4'hF, 1'b1, 1'b0, 2);
    do_load(4'hF, 4'hF, 1'b1, 1'b0, 3);
    do_load(4'hF, 4'hF, 1'b1, 1'b0, 0);
    // Fixed priority: lowest eligible index, mask applied.
    do_load(4'b1010, 4'hF, 1'b0, 1'b0, 1);
    do_load(4'hF, 4'b1100, 1'b0, 1'b0, 2);
    // Underruns from empty req and empty mask; ptr stays at 3.
    do_load(4'b0000, 4'hF, 1'b0, 1'b0, -1);
    do_load(4'hF, 4'b0000, 1'b1, 1'b0, -1);
    do_load(4'hF, 4'hF, 1'b1, 1'b0, 3);
    // Lock: source 2 holds the grant until its req drops.
    do_load(4'b0100, 4'hF, 1'b1, 1'b1, 2);
    do_load(4'hF, 4'hF, 1'b1, 1'b1, 2);
    do_load(4'hF, 4'hF, 1'b1, 1'b1, 2);
    do_load(4'b1011, 4'hF, 1'b1, 1'b1, 3);
    do_load(4'hF, 4'hF, 1'b1, 1'b0, 0);
    // Masked owner loses the lock.
    do_load(4'hF, 4'hF, 1'b1, 1'b1, 1);
    do_load(4'hF, 4'b1101, 1'b1, 1'b1, 2);
    do_load(4'hF, 4'hF, 1'b1, 1'b0, 3);

    // Overrun: back-to-back loads give one grant and one overrun pulse at t+2.
    @(negedge clk);
    req = 4'hF; mask = 4'hF; rr_mode = 1'b1; lock_en = 1'b0; load = 1'b1;
    c0 = cyc;
    sb.push_back(make_exp(c0, 0));
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    repeat (3) @(negedge clk);
    check("overrun_count", ov_cnt, 1);
    check("overrun_cycle", ov_cyc, c0 + 2);

    // Reset during ARB: outputs clear, the interrupted load never acks.
    @(negedge clk) load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    reset = 1'b0;
    #1;
    check_quiet("arb_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_load(4'hF, 4'hF, 1'b1, 1'b0, 0);
    do_load(4'hF, 4'hF, 1'b1, 1'b0, 1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
    check("overrun_total", ov_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
